// File: rtl/seq_detect_stream_ctrl_if.sv
// Word stream handshake between a word-wide producer and the serialising
// detector controller.
//   word_valid  producer -> controller  a word is offered
//   word_data   producer -> controller  word payload, shifted MSB first
//   word_last   producer -> controller  word closes its frame
//   word_ready  controller -> producer  controller accepts a word this cycle
interface seq_detect_stream_ctrl_if #(
  parameter int unsigned WORD_W = 16
);
  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic              word_last;
  logic              word_ready;

  modport master (
    output word_valid,
    output word_data,
    output word_last,
    input  word_ready
  );

  modport slave (
    input  word_valid,
    input  word_data,
    input  word_last,
    output word_ready
  );
endinterface

// File: rtl/seq_detect_stream_ctrl.sv
// Serialising controller around a programmable-pattern bit-sequence detector.
// Words arrive over a valid/ready handshake and are shifted MSB-first, one bit
// per clock, through a window matcher. Each detection gives a one-cycle
// det_pulse and bumps a saturating per-frame match_count; word_last ends a
// frame with a one-cycle done pulse.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high; clears all state
//   cfg_pattern  pattern; bit [len-1] is matched first
//   cfg_len      pattern length; 0 or >PAT_W means PAT_W
//   cfg_overlap  1 = overlapping matches, 0 = non-overlapping
//   flush        synchronous abort of the current frame
//   word_if      word stream (slave side)
//   busy         frame in progress
//   det_pulse    one-cycle pulse per detection
//   match_count  detections in the current or last frame, saturating
//   done         one-cycle pulse at end of frame
module seq_detect_stream_ctrl #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned PAT_W  = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PAT_W-1:0]           cfg_pattern,
  input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
  input  logic                       cfg_overlap,
  input  logic                       flush,
  seq_detect_stream_ctrl_if.slave    word_if,
  output logic                       busy,
  output logic                       det_pulse,
  output logic [CNT_W-1:0]           match_count,
  output logic                       done
);

  localparam int unsigned LEN_W = $clog2(PAT_W + 1);
  localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic               last_q, last_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [PAT_W-1:0]   hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               det_q, det_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;

  logic               xfer_c;
  logic               bit_c;
  logic [PAT_W-1:0]   hist_shift_c;
  logic [PAT_W-1:0]   mask_c;
  logic               hit_c;
  logic [LEN_W-1:0]   fill_inc_c;
  logic [LEN_W-1:0]   eff_len_c;

  assign word_if.word_ready = ready_q;
  assign busy        = busy_q;
  assign det_pulse   = det_q;
  assign match_count = cnt_q;
  assign done        = done_q;

  // Out-of-range lengths collapse to the full window
  always_comb begin
    eff_len_c = cfg_len;
    if ((cfg_len == '0) || (cfg_len > LEN_W'(PAT_W))) begin
      eff_len_c = LEN_W'(PAT_W);
    end
  end

  // Window matcher on the history as it will look after the current bit
  always_comb begin
    xfer_c       = word_if.word_valid & ready_q;
    bit_c        = word_q[idx_q];
    hist_shift_c = {hist_q[PAT_W-2:0], bit_c};
    for (int unsigned i = 0; i < PAT_W; i++) begin
      mask_c[i] = (LEN_W'(i) < len_q);
    end
    // fill counts bits since frame start or last non-overlapping match
    hit_c      = (({1'b0, fill_q} + (LEN_W+1)'(1)) >= {1'b0, len_q}) &&
                 (((hist_shift_c ^ pat_q) & mask_c) == '0);
    fill_inc_c = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + LEN_W'(1);
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    last_d  = last_q;
    idx_d   = idx_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    cnt_d   = cnt_q;
    det_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (xfer_c) begin
          pat_d   = cfg_pattern;
          len_d   = eff_len_c;
          ovl_d   = cfg_overlap;
          hist_d  = '0;
          fill_d  = '0;
          cnt_d   = '0;
          word_d  = word_if.word_data;
          last_d  = word_if.word_last;
          idx_d   = IDX_W'(WORD_W - 1);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        hist_d = hist_shift_c;
        fill_d = (hit_c && !ovl_q) ? '0 : fill_inc_c;
        if (hit_c) begin
          det_d = 1'b1;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        idx_d = idx_q - IDX_W'(1);
        if (idx_q == '0) begin
          state_d = last_q ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        // Frame continues: history, fill, count and shadow config persist
        if (xfer_c) begin
          word_d  = word_if.word_data;
          last_d  = word_if.word_last;
          idx_d   = IDX_W'(WORD_W - 1);
          state_d = S_SHIFT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over any transfer or bit processing this cycle
    if (flush && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      fill_d  = '0;
      hist_d  = '0;
      det_d   = 1'b0;
    end

    ready_d = (state_d == S_IDLE) || (state_d == S_WAIT);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= '0;
      len_q   <= LEN_W'(PAT_W);
      ovl_q   <= 1'b0;
      cnt_q   <= '0;
      det_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      cnt_q   <= cnt_d;
      det_q   <= det_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

endmodule
